split_rr_arbiter: RTL

- Bus arbiter for the serial system bus: shares one bus between N_MASTERS masters with rotating (round-robin) priority.
- Supports one outstanding split transaction. When the split slave parks the current owner, the bus is freed for others; when the slave signals completion, that owner resumes with top priority.
- Sits between the master request lines and the bus mux. Its sel output drives the address/data mux select.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/split_rr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the split-capable round-robin bus arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // sel encoding: 0 means no owner, k+1 means master k.
    localparam int SEL_NONE = 0;

    function automatic int idx_to_sel(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-one finder: returns the first set request at or after ptr_i,
// wrapping at N_MASTERS.
module rr_priority_pick #(
    parameter int N_MASTERS = 2,
    parameter int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    int   cand;
    logic found;

    always_comb begin
        found   = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N_MASTERS) begin
                cand = cand - N_MASTERS;
            end
            if (!found && req_i[IDX_W'(cand)]) begin
                found = 1'b1;
                idx_o = IDX_W'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/split_rr_arbiter.sv
// Round-robin bus arbiter with one outstanding split transaction and an
// optional grant-tenure timeout.
module split_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int SEL_W     = $clog2(N_MASTERS + 1),
    parameter int MAX_HOLD  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] grant,
    output logic [SEL_W-1:0]     sel,
    input  logic                 split_i,
    input  logic                 split_done_i,
    output logic                 split_pending_o,
    output logic [SEL_W-1:0]     split_owner_o,
    output logic                 timeout_o
);

    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_CAP = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                resume_q, resume_d;
    logic                split_pending_q, split_pending_d;
    logic [SEL_W-1:0]    split_owner_q, split_owner_d;
    logic                timeout_q, timeout_d;

    logic [IDX_W-1:0]     park_idx;
    logic [N_MASTERS-1:0] park_oh;
    logic [N_MASTERS-1:0] owner_oh;
    logic [N_MASTERS-1:0] elig_req;
    logic                 rivals;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (int'(idx) == N_MASTERS - 1) ? '0 : idx + IDX_W'(1);
    endfunction

    assign park_idx = IDX_W'(int'(split_owner_q) - 1);

    // The parked master stays invisible to RR and to the timeout until its
    // slave reports completion.
    always_comb begin
        park_oh           = '0;
        park_oh[park_idx] = 1'b1;
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        elig_req          = req & ~((split_pending_q && !resume_q) ? park_oh : '0);
        rivals            = |(elig_req & ~owner_oh);
    end

    rr_priority_pick #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i   (elig_req),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            owner_q         <= '0;
            ptr_q           <= '0;
            hold_q          <= '0;
            resume_q        <= 1'b0;
            split_pending_q <= 1'b0;
            split_owner_q   <= '0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            ptr_q           <= ptr_d;
            hold_q          <= hold_d;
            resume_q        <= resume_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            timeout_q       <= timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        ptr_d           = ptr_q;
        hold_d          = hold_q;
        resume_d        = resume_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        timeout_d       = 1'b0;

        if (split_done_i && split_pending_q) begin
            resume_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (resume_q) begin
                    // Resume beats RR; a parked master that gave up abandons the split.
                    resume_d        = 1'b0;
                    split_pending_d = 1'b0;
                    split_owner_d   = SEL_W'(SEL_NONE);
                    if (req[park_idx]) begin
                        state_d = GRANT;
                        owner_d = park_idx;
                        ptr_d   = next_ptr(park_idx);
                        hold_d  = '0;
                    end
                end else if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick_idx;
                    ptr_d   = next_ptr(pick_idx);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (split_i && !split_pending_q) begin
                    state_d         = IDLE;
                    split_pending_d = 1'b1;
                    split_owner_d   = SEL_W'(idx_to_sel(int'(owner_q)));
                end else if ((MAX_HOLD > 0) && (hold_q >= HOLD_CAP) && rivals) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (hold_q < HOLD_CAP) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        sel   = SEL_W'(SEL_NONE);
        if (state_q == GRANT) begin
            grant[owner_q] = 1'b1;
            sel            = SEL_W'(idx_to_sel(int'(owner_q)));
        end
        split_pending_o = split_pending_q;
        split_owner_o   = split_owner_q;
        timeout_o       = timeout_q;
    end

endmodule
